aicd_ana_scan: RTL and testbench

Analog channel scan controller for the AICD playground. It owns the analog switch enables for the six usable analog pins (ua[5:0]) and sequences them one channel at a time, with break-before-make dead time, a programmable settle interval and a fixed-length comparator sampling window. It accumulates the comparator ones-count per channel into a readable result bank. It sits between the digital control logic (driven from ui_in/uio_in) and the analog switch and comparator macros.

---
 rtl/aicd_ana_scan.sv | 224 ++++++++++++++++++++++
 tb/tb_aicd_ana_scan.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/aicd_ana_scan.sv
`default_nettype none
// ============================================================================
// Module   : aicd_ana_scan
// Purpose  : Analog channel scan controller. Visits every channel selected in
//            a latched mask in ascending order. Each visit is a break-before-
//            make gap with all switches open, a programmable settle interval
//            with the channel switch closed, and a fixed-length comparator
//            sampling window. The comparator ones-count for each channel is
//            kept in a readable result bank.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            start, abort    - begin a scan (IDLE only) / cancel a running scan
//            chan_mask       - channels to scan, latched at start
//            settle          - settle cycles per channel, latched at start
//                              (0 is treated as 1)
//            cmp_in          - comparator output, already synchronous to clk
//            sw_en, samp     - registered switch enables / sampling strobe
//            busy, done      - scan in progress / one-cycle completion pulse
//            rd_sel, rd_data - combinational read port of the result bank
// Revision : 1.0 - initial release
// ============================================================================
module aicd_ana_scan #(
  parameter int NCH      = 6,
  parameter int DEAD     = 2,
  parameter int NSAMP    = 16,
  parameter int SETTLE_W = 8,
  parameter int CNT_W    = $clog2(NSAMP) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [NCH-1:0]      chan_mask,
  input  logic [SETTLE_W-1:0] settle,
  input  logic                cmp_in,
  output logic [NCH-1:0]      sw_en,
  output logic                samp,
  output logic                busy,
  output logic                done,
  input  logic [2:0]          rd_sel,
  output logic [CNT_W-1:0]    rd_data
);

  localparam int C_CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int C_W_A   = (SETTLE_W > CNT_W) ? SETTLE_W : CNT_W;
  localparam int C_W_D   = $clog2(DEAD + 1);
  // One shared interval timer must cover the dead, settle and sample phases.
  localparam int C_TMR_W = (C_W_A > C_W_D) ? C_W_A : C_W_D;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DEAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_STORE  = 3'd4
  } state_t;

  state_t              r_state, w_state_n;
  logic [C_TMR_W-1:0]  r_tmr, w_tmr_n;
  logic [C_CH_W-1:0]   r_ch, w_ch_n;
  logic [CNT_W-1:0]    r_acc, w_acc_n;
  logic [NCH-1:0]      r_mask, w_mask_n;
  logic [SETTLE_W-1:0] r_settle, w_settle_n;
  logic [NCH-1:0]      r_sw_en, w_sw_en_n;
  logic                r_samp, w_samp_n;
  logic                r_done, w_done_n;
  logic                w_store;
  logic [CNT_W-1:0]    r_result [NCH];

  logic [C_CH_W-1:0]   w_first_ch;
  logic [C_CH_W-1:0]   w_nxt_ch;
  logic                w_nxt_found;
  logic [C_TMR_W-1:0]  w_settle_len;

  // Lowest set bit of the incoming mask (descending scan so lowest wins).
  always_comb begin
    w_first_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (chan_mask[i]) w_first_ch = C_CH_W'(i);
    end
  end

  // Next set bit of the latched mask strictly above the current channel.
  always_comb begin
    w_nxt_ch    = '0;
    w_nxt_found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (r_mask[i] && (i > int'(r_ch))) begin
        w_nxt_ch    = C_CH_W'(i);
        w_nxt_found = 1'b1;
      end
    end
  end

  assign w_settle_len = (r_settle == '0) ? C_TMR_W'(1) : C_TMR_W'(r_settle);

  // Next-state and next-output logic.
  always_comb begin
    w_state_n  = r_state;
    w_tmr_n    = r_tmr;
    w_ch_n     = r_ch;
    w_acc_n    = r_acc;
    w_mask_n   = r_mask;
    w_settle_n = r_settle;
    w_done_n   = 1'b0;
    w_store    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (chan_mask != '0) begin
            w_mask_n   = chan_mask;
            w_settle_n = settle;
            w_ch_n     = w_first_ch;
            w_tmr_n    = '0;
            w_state_n  = S_DEAD;
          end else begin
            w_done_n = 1'b1;
          end
        end
      end
      S_DEAD: begin
        if (r_tmr == C_TMR_W'(DEAD - 1)) begin
          w_tmr_n   = '0;
          w_state_n = S_SETTLE;
        end else begin
          w_tmr_n = r_tmr + C_TMR_W'(1);
        end
      end
      S_SETTLE: begin
        if (r_tmr == (w_settle_len - C_TMR_W'(1))) begin
          w_tmr_n   = '0;
          w_acc_n   = '0;
          w_state_n = S_SAMPLE;
        end else begin
          w_tmr_n = r_tmr + C_TMR_W'(1);
        end
      end
      S_SAMPLE: begin
        w_acc_n = r_acc + CNT_W'(cmp_in);
        if (r_tmr == C_TMR_W'(NSAMP - 1)) begin
          w_tmr_n   = '0;
          w_state_n = S_STORE;
        end else begin
          w_tmr_n = r_tmr + C_TMR_W'(1);
        end
      end
      S_STORE: begin
        w_store = 1'b1;
        if (w_nxt_found) begin
          w_ch_n    = w_nxt_ch;
          w_state_n = S_DEAD;
        end else begin
          w_done_n  = 1'b1;
          w_state_n = S_IDLE;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    // Abort overrides everything: the in-flight channel is never written and
    // no completion pulse is produced.
    if (abort && (r_state != S_IDLE)) begin
      w_state_n = S_IDLE;
      w_tmr_n   = '0;
      w_store   = 1'b0;
      w_done_n  = 1'b0;
    end

    // Outputs are registered, so they are decoded from the next state. Every
    // channel is entered via DEAD, so sw_en always passes through zero.
    w_sw_en_n = '0;
    if ((w_state_n == S_SETTLE) || (w_state_n == S_SAMPLE)) begin
      w_sw_en_n = NCH'(1) << w_ch_n;
    end
    w_samp_n = (w_state_n == S_SAMPLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_tmr    <= '0;
      r_ch     <= '0;
      r_acc    <= '0;
      r_mask   <= '0;
      r_settle <= '0;
      r_sw_en  <= '0;
      r_samp   <= 1'b0;
      r_done   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        r_result[i] <= '0;
      end
    end else begin
      r_state  <= w_state_n;
      r_tmr    <= w_tmr_n;
      r_ch     <= w_ch_n;
      r_acc    <= w_acc_n;
      r_mask   <= w_mask_n;
      r_settle <= w_settle_n;
      r_sw_en  <= w_sw_en_n;
      r_samp   <= w_samp_n;
      r_done   <= w_done_n;
      for (int i = 0; i < NCH; i++) begin
        if (w_store && (r_ch == C_CH_W'(i))) r_result[i] <= r_acc;
      end
    end
  end

  assign sw_en = r_sw_en;
  assign samp  = r_samp;
  assign busy  = (r_state != S_IDLE);
  assign done  = r_done;

  // Out-of-range read indices return zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_sel == 3'(i)) rd_data = r_result[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aicd_ana_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_aicd_ana_scan
// Purpose  : Self-checking bench for aicd_ana_scan. A table of scan records
//            (mask, settle, comparator pattern, hand-computed result and done
//            cycle) is replayed with per-cycle output checks against the
//            channel timeline, followed by hand-written reset and abort
//            sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aicd_ana_scan;

  localparam int NCH   = 6;
  localparam int DEAD  = 2;
  localparam int NSAMP = 16;
  localparam int CNT_W = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [5:0] chan_mask;
  logic [7:0] settle;
  logic       cmp_in;
  logic [5:0] sw_en;
  logic       samp;
  logic       busy;
  logic       done;
  logic [2:0] rd_sel;
  logic [4:0] rd_data;

  always #5 clk = ~clk;

  aicd_ana_scan dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .chan_mask (chan_mask),
    .settle    (settle),
    .cmp_in    (cmp_in),
    .sw_en     (sw_en),
    .samp      (samp),
    .busy      (busy),
    .done      (done),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data)
  );

  typedef struct {
    logic [5:0] mask;
    logic [7:0] settle;
    int         mode;        // 0: cmp_in=0, 1: cmp_in=1, 2: alternating
    int         exp_val;     // result expected for every scanned channel
    int         done_cyc;    // cycle of the done pulse, start at cycle 0
    int         restart_at;  // nonzero: pulse start (new mask/settle) here
    bit         abort0;      // assert abort together with start
  } vec_t;

  vec_t tbl[6];

  int n_cmp = 0;
  int n_bad = 0;
  int chlist[NCH];
  int nscan;
  int slen;
  logic [CNT_W-1:0] bank[8];

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic plan(input logic [5:0] m, input logic [7:0] s);
    nscan = 0;
    for (int i = 0; i < NCH; i++) begin
      if (m[i]) begin
        chlist[nscan] = i;
        nscan++;
      end
    end
    slen = (s == 8'd0) ? 1 : int'(s);
  endtask

  // Expected outputs in cycle c of a scan whose start was seen in cycle 0.
  task automatic expect_at(input int c, output logic [5:0] esw,
                           output logic es, output logic eb, output logic ed);
    int p, k, o;
    p   = DEAD + slen + NSAMP + 1;
    esw = '0;
    es  = 1'b0;
    eb  = 1'b0;
    ed  = (c == 1 + nscan * p);
    if (c >= 1) begin
      k = (c - 1) / p;
      o = (c - 1) % p;
      if (k < nscan) begin
        eb = 1'b1;
        if (o >= DEAD && o < DEAD + slen + NSAMP) esw = 6'd1 << chlist[k];
        es = (o >= DEAD + slen) && (o < DEAD + slen + NSAMP);
      end
    end
  endtask

  task automatic check_cycle(input int c);
    logic [5:0] esw;
    logic es, eb, ed;
    expect_at(c, esw, es, eb, ed);
    chk("sw_en", c, 32'(sw_en), 32'(esw));
    chk("samp",  c, 32'(samp),  32'(es));
    chk("busy",  c, 32'(busy),  32'(eb));
    chk("done",  c, 32'(done),  32'(ed));
  endtask

  task automatic check_bank();
    for (int i = 0; i < 8; i++) begin
      rd_sel = 3'(i);
      #1;
      chk("rd_data", i, 32'(rd_data), 32'(bank[i]));
    end
  endtask

  task automatic run_scan(input vec_t r);
    int seen_done;
    seen_done = -1;
    plan(r.mask, r.settle);
    chan_mask = r.mask;
    settle    = r.settle;
    start     = 1'b1;
    abort     = r.abort0;
    for (int c = 0; c <= r.done_cyc + 3; c++) begin
      if (c == 1) begin
        start = 1'b0;
        abort = 1'b0;
      end
      if (r.restart_at != 0 && c == r.restart_at) begin
        start     = 1'b1;
        chan_mask = 6'b111111;
        settle    = 8'd9;
      end
      if (r.restart_at != 0 && c == r.restart_at + 1) start = 1'b0;
      cmp_in = (r.mode == 1) ? 1'b1 : (r.mode == 2) ? (c % 2 == 1) : 1'b0;
      check_cycle(c);
      if (done === 1'b1 && seen_done < 0) seen_done = c;
      tick();
    end
    chk("done_cycle", r.done_cyc, 32'(seen_done), 32'(r.done_cyc));
    for (int i = 0; i < NCH; i++) begin
      if (r.mask[i]) bank[i] = CNT_W'(r.exp_val);
    end
    check_bank();
  endtask

  initial begin
    tbl[0] = '{6'b000000, 8'd5, 1, 0,  1,   0,  1'b0}; // empty mask
    tbl[1] = '{6'b000100, 8'd4, 1, 16, 24,  10, 1'b0}; // single, start while busy
    tbl[2] = '{6'b111111, 8'd2, 1, 16, 127, 0,  1'b0}; // all channels
    tbl[3] = '{6'b000010, 8'd0, 0, 0,  21,  0,  1'b1}; // settle 0, abort+start
    tbl[4] = '{6'b010100, 8'd3, 0, 0,  45,  0,  1'b0}; // two channels, zeros
    tbl[5] = '{6'b100001, 8'd1, 2, 8,  41,  0,  1'b0}; // two channels, alternating

    for (int i = 0; i < 8; i++) bank[i] = '0;

    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    cmp_in    = 1'b0;
    chan_mask = '0;
    settle    = '0;
    rd_sel    = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_sw_en", 0, 32'(sw_en), 32'd0);
    chk("rst_samp",  0, 32'(samp),  32'd0);
    chk("rst_busy",  0, 32'(busy),  32'd0);
    chk("rst_done",  0, 32'(done),  32'd0);
    check_bank();
    tick();

    for (int v = 0; v < 6; v++) begin
      run_scan(tbl[v]);
      tick();
    end

    // Abort in the 5th SAMPLE cycle of ch5 (mask 100001, settle 1 -> cycle 28).
    plan(6'b100001, 8'd1);
    chan_mask = 6'b100001;
    settle    = 8'd1;
    start     = 1'b1;
    cmp_in    = 1'b1;
    for (int c = 0; c <= 28; c++) begin
      if (c == 1) start = 1'b0;
      if (c == 28) abort = 1'b1;
      check_cycle(c);
      tick();
    end
    abort = 1'b0;
    chk("abort_sw_en", 29, 32'(sw_en), 32'd0);
    chk("abort_samp",  29, 32'(samp),  32'd0);
    chk("abort_busy",  29, 32'(busy),  32'd0);
    chk("abort_done",  29, 32'(done),  32'd0);
    for (int c = 30; c < 42; c++) begin
      tick();
      chk("abort_no_done", c, 32'(done), 32'd0);
      chk("abort_idle",    c, 32'(busy), 32'd0);
    end
    bank[0] = 5'd16;   // ch0 completed; ch5 keeps 8 from the previous scan
    check_bank();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
